// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizing for the round-robin register write arbiter.
// Optional burst-lock support is selected with the ARB_LOCK_EN macro.
package reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle of the register write arbiter: requests, data, grants and register drive.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = reg_arb_pkg::NUM_REQ_DEF,
    parameter int DATA_W  = reg_arb_pkg::DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         reg_d;
    logic                      reg_en;
    logic                      busy;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;

    modport master (output req, output wdata, output lock,
                    input gnt, input reg_d, input reg_en, input busy);
    modport slave  (input req, input wdata, input lock,
                    output gnt, output reg_d, output reg_en, output busy);
`else
    modport master (output req, output wdata,
                    input gnt, input reg_d, input reg_en, input busy);
    modport slave  (input req, input wdata,
                    output gnt, output reg_d, output reg_en, output busy);
`endif
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer, find the first set bit,
// then map the offset back to an absolute requester index.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               valid_o
);
    logic [NUM_REQ-1:0] req_rot;
    logic [PTR_W-1:0]   offset;
    logic [PTR_W:0]     sum;

    // Bit k of req_rot is requester (ptr + k) mod NUM_REQ.
    always_comb begin
        req_rot = req_i;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (ptr_i == PTR_W'(p)) begin
                req_rot = (req_i >> p) | (req_i << (NUM_REQ - p));
            end
        end
    end

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = PTR_W'(k);
            end
        end
    end

    assign sum      = {1'b0, ptr_i} + {1'b0, offset};
    assign winner_o = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                   : sum[PTR_W-1:0];
    assign valid_o  = |req_i;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one enable-loaded register among NUM_REQ requesters,
// issuing one single-cycle write per grant. Define ARB_LOCK_EN to add burst lock.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            reset,
    reg_write_arbiter_if.slave bus
);
    arb_state_e          state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [DATA_W-1:0]   reg_d_q;
    logic                reg_en_q;
    logic                busy_q;

    logic [PTR_W-1:0]    win_d;
    logic                win_valid_d;
    logic [PTR_W-1:0]    ptr_adv_d;
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (win_d),
        .valid_o  (win_valid_d)
    );

    assign ptr_adv_d = (win_d == PTR_W'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            reg_d_q  <= '0;
            reg_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid_d) begin
                        state_q  <= WRITE;
                        gnt_q    <= NUM_REQ'(1) << win_d;
                        reg_d_q  <= wdata_arr[win_d];
                        reg_en_q <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef ARB_LOCK_EN
                        // A locked winner keeps top priority for its next request.
                        ptr_q    <= bus.lock[win_d] ? win_d : ptr_adv_d;
`else
                        ptr_q    <= ptr_adv_d;
`endif
                    end
                end
                WRITE: begin
                    // Requests are deliberately ignored here; reg_d keeps the last value.
                    state_q  <= IDLE;
                    gnt_q    <= '0;
                    reg_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.reg_d  = reg_d_q;
    assign bus.reg_en = reg_en_q;
    assign bus.busy   = busy_q;

endmodule
